// File: rtl/nmr_pulse_streamer.sv
// nmr_pulse_streamer: turns one {idly, pls, edly} command per BT_START rising
// edge into a single RF gate pulse (idly low, pls high, edly low), then
// raises BT_DONE for the upstream sequencer.
// Optional amplifier gate lead: define NMR_PLS_GATE_EN to add GATE_OUT.
module nmr_pulse_streamer #(
   parameter int IDLY_WIDTH = 32,
   parameter int PLS_WIDTH  = 32,
   parameter int EDLY_WIDTH = 32,
   parameter int GATE_PRE   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  BT_START,
   output logic                  BT_DONE,
   input  logic [IDLY_WIDTH-1:0] idly_reg,
   input  logic [PLS_WIDTH-1:0]  pls_reg,
   input  logic [EDLY_WIDTH-1:0] edly_reg,
   output logic                  PULSE_OUT,
   output logic                  BUSY,
`ifdef NMR_PLS_GATE_EN
   output logic                  GATE_OUT,
`endif
   output logic                  START_IGN
);

   typedef enum logic [2:0] {S_IDLE, S_IDLY, S_PLS, S_EDLY, S_END} state_t;

   state_t                state, state_nx;
   logic                  bt_start_q;
   logic                  start_edge;
   logic [IDLY_WIDTH-1:0] idly_cnt, idly_cnt_nx;
   logic [PLS_WIDTH-1:0]  pls_cnt, pls_cnt_nx;
   logic [EDLY_WIDTH-1:0] edly_cnt, edly_cnt_nx;
   // Latched "phase present" flags; counters hold N-1 so zero cannot be seen there.
   logic                  pls_nz, pls_nz_nx;
   logic                  edly_nz, edly_nz_nx;

   assign start_edge = BT_START & ~bt_start_q;

   // Next-state and counter update; counters are loaded at the start edge
   // (this is the parameter latch) and only the active phase decrements.
   always_comb begin
      state_nx    = state;
      idly_cnt_nx = idly_cnt;
      pls_cnt_nx  = pls_cnt;
      edly_cnt_nx = edly_cnt;
      pls_nz_nx   = pls_nz;
      edly_nz_nx  = edly_nz;
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               idly_cnt_nx = idly_reg - IDLY_WIDTH'(1);
               pls_cnt_nx  = pls_reg - PLS_WIDTH'(1);
               edly_cnt_nx = edly_reg - EDLY_WIDTH'(1);
               pls_nz_nx   = |pls_reg;
               edly_nz_nx  = |edly_reg;
               if (|idly_reg)     state_nx = S_IDLY;
               else if (|pls_reg) state_nx = S_PLS;
               else if (|edly_reg) state_nx = S_EDLY;
               else               state_nx = S_END;
            end
         end
         S_IDLY: begin
            if (idly_cnt == '0) begin
               if (pls_nz)       state_nx = S_PLS;
               else if (edly_nz) state_nx = S_EDLY;
               else              state_nx = S_END;
            end else begin
               idly_cnt_nx = idly_cnt - IDLY_WIDTH'(1);
            end
         end
         S_PLS: begin
            if (pls_cnt == '0) state_nx = edly_nz ? S_EDLY : S_END;
            else               pls_cnt_nx = pls_cnt - PLS_WIDTH'(1);
         end
         S_EDLY: begin
            if (edly_cnt == '0) state_nx = S_END;
            else                edly_cnt_nx = edly_cnt - EDLY_WIDTH'(1);
         end
         S_END:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State, counters and registered outputs; all outputs come from next-state
   // decode so they change on the same edge as the phase they describe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         bt_start_q <= 1'b0;
         idly_cnt   <= '0;
         pls_cnt    <= '0;
         edly_cnt   <= '0;
         pls_nz     <= 1'b0;
         edly_nz    <= 1'b0;
         BT_DONE    <= 1'b1;
         BUSY       <= 1'b0;
         PULSE_OUT  <= 1'b0;
         START_IGN  <= 1'b0;
      end else begin
         state      <= state_nx;
         bt_start_q <= BT_START;
         idly_cnt   <= idly_cnt_nx;
         pls_cnt    <= pls_cnt_nx;
         edly_cnt   <= edly_cnt_nx;
         pls_nz     <= pls_nz_nx;
         edly_nz    <= edly_nz_nx;
         BT_DONE    <= (state_nx == S_IDLE);
         BUSY       <= (state_nx != S_IDLE);
         PULSE_OUT  <= (state_nx == S_PLS);
         if (start_edge && (state != S_IDLE)) START_IGN <= 1'b1;
      end
   end

`ifdef NMR_PLS_GATE_EN
   // Lead threshold one bit wider than the counter so large GATE_PRE compares sanely.
   localparam logic [IDLY_WIDTH:0] GATE_LEAD = (IDLY_WIDTH+1)'(GATE_PRE);

   logic gate_nx;

   // Counter value N-1-j in IDLY cycle j means "cnt < GATE_PRE" marks the last
   // GATE_PRE cycles; a command with no pulse never opens the gate.
   always_comb begin
      gate_nx = 1'b0;
      if (pls_nz_nx) begin
         if (state_nx == S_PLS)
            gate_nx = 1'b1;
         else if ((state_nx == S_IDLY) && ({1'b0, idly_cnt_nx} < GATE_LEAD))
            gate_nx = 1'b1;
      end
   end

   // Registered amplifier gate, falls on the same edge as PULSE_OUT.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) GATE_OUT <= 1'b0;
      else     GATE_OUT <= gate_nx;
   end
`endif

endmodule

// File: tb/tb_nmr_pulse_streamer.sv
// Bench for nmr_pulse_streamer: stimulus pushes the expected per-command pulse
// shape into a queue; a negedge monitor measures each BT_DONE-low window and
// compares it against the queue head.
module tb_nmr_pulse_streamer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        BT_START = 1'b0;
   logic [31:0] idly_reg = '0;
   logic [31:0] pls_reg = '0;
   logic [31:0] edly_reg = '0;
   logic        BT_DONE, PULSE_OUT, BUSY, START_IGN;
`ifdef NMR_PLS_GATE_EN
   logic        GATE_OUT;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int pfirst;
      int plen;
      int pruns;
      int dlen;
      int gfirst;
      int glen;
   } exp_t;

   exp_t sb[$];

   nmr_pulse_streamer dut (
      .CLK       (CLK),
      .RST       (RST),
      .BT_START  (BT_START),
      .BT_DONE   (BT_DONE),
      .idly_reg  (idly_reg),
      .pls_reg   (pls_reg),
      .edly_reg  (edly_reg),
      .PULSE_OUT (PULSE_OUT),
      .BUSY      (BUSY),
`ifdef NMR_PLS_GATE_EN
      .GATE_OUT  (GATE_OUT),
`endif
      .START_IGN (START_IGN)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: one record per BT_DONE-low window, aborted by reset.
   bit m_active = 0;
   int m_t0, m_dlen, m_pfirst, m_plen, m_pruns, m_gfirst, m_glen;
   bit m_pprev;
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST) begin
            m_active = 0;
         end else begin
            if (!m_active && !BT_DONE) begin
               m_active = 1; m_t0 = cyc; m_dlen = 0;
               m_pfirst = -1; m_plen = 0; m_pruns = 0; m_pprev = 0;
               m_gfirst = -1; m_glen = 0;
            end
            if (m_active) begin
               if (!BT_DONE) begin
                  m_dlen++;
                  if (PULSE_OUT) begin
                     if (m_pfirst < 0) m_pfirst = cyc - m_t0;
                     m_plen++;
                     if (!m_pprev) m_pruns++;
                  end
                  m_pprev = PULSE_OUT;
`ifdef NMR_PLS_GATE_EN
                  if (GATE_OUT) begin
                     if (m_gfirst < 0) m_gfirst = cyc - m_t0;
                     m_glen++;
                  end
`endif
               end else begin
                  m_active = 0;
                  if (sb.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_command: got dlen=%0d expected no command", m_dlen);
                  end else begin
                     e = sb.pop_front();
                     chk("pulse_first", m_pfirst, e.pfirst);
                     chk("pulse_len",   m_plen,   e.plen);
                     chk("pulse_runs",  m_pruns,  e.pruns);
                     chk("done_low",    m_dlen,   e.dlen);
`ifdef NMR_PLS_GATE_EN
                     chk("gate_first",  m_gfirst, e.gfirst);
                     chk("gate_len",    m_glen,   e.glen);
`endif
                  end
               end
            end
         end
      end
   end

   // Issue one command; BT_START held for 'hold' cycles, inputs scrambled after the latch edge.
   task automatic issue(input int i, input int p, input int e, input int hold, input bit push);
      exp_t x;
      int lead;
      @(negedge CLK);
      idly_reg = i; pls_reg = p; edly_reg = e; BT_START = 1'b1;
      if (push) begin
         lead     = (i < 8) ? i : 8;
         x.pfirst = (p > 0) ? i : -1;
         x.plen   = p;
         x.pruns  = (p > 0) ? 1 : 0;
         x.dlen   = i + p + e + 1;
         x.gfirst = (p > 0) ? i - lead : -1;
         x.glen   = (p > 0) ? lead + p : 0;
         sb.push_back(x);
      end
      @(negedge CLK);
      idly_reg = 7; pls_reg = 7; edly_reg = 7;
      repeat (hold - 1) @(negedge CLK);
      BT_START = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!BT_DONE && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 2000) begin
         checks++; failures++;
         $display("FAIL idle_timeout: got BT_DONE=%0d expected 1 within 2000 cycles", BT_DONE);
      end
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish by 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_done",  int'(BT_DONE),   1);
      chk("rst_pulse", int'(PULSE_OUT), 0);
      chk("rst_busy",  int'(BUSY),      0);
      chk("rst_ign",   int'(START_IGN), 0);
`ifdef NMR_PLS_GATE_EN
      chk("rst_gate",  int'(GATE_OUT),  0);
`endif

      issue(5, 3, 4, 1, 1);  wait_idle();
      issue(0, 2, 0, 1, 1);  wait_idle();
      issue(0, 0, 0, 1, 1);  wait_idle();
      issue(1, 1, 1, 1, 1);  wait_idle();
      issue(0, 0, 3, 1, 1);  wait_idle();
      issue(3, 5, 0, 1, 1);  wait_idle();
      issue(20, 5, 2, 1, 1); wait_idle();

      // Level held high for 20 cycles must start exactly one command.
      issue(2, 3, 1, 20, 1); wait_idle();
      chk("held_no_ign", int'(START_IGN), 0);

      // Second edge while busy, with different values, must be ignored.
      issue(10, 10, 10, 1, 1);
      repeat (5) @(negedge CLK);
      idly_reg = 1; pls_reg = 1; edly_reg = 1; BT_START = 1'b1;
      @(negedge CLK);
      BT_START = 1'b0;
      wait_idle();
      chk("busy_ign", int'(START_IGN), 1);

      // Reset in the middle of the pulse aborts at once.
      issue(4, 8, 2, 1, 0);
      repeat (5) @(negedge CLK);
      chk("mid_pulse_high", int'(PULSE_OUT), 1);
      chk("mid_busy_high",  int'(BUSY),      1);
      #2 RST = 1'b1;
      #1;
      chk("abort_pulse", int'(PULSE_OUT), 0);
      chk("abort_busy",  int'(BUSY),      0);
      chk("abort_done",  int'(BT_DONE),   1);
      chk("abort_ign",   int'(START_IGN), 0);
      @(negedge CLK);
      #2 RST = 1'b0;
      repeat (2) @(negedge CLK);

      issue(3, 2, 2, 1, 1);  wait_idle();

      chk("queue_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nmr_pulse_streamer.md
Name: nmr_pulse_streamer

Overview:
- Downstream stage of the SRAM command sequencer. It consumes one command per BT_START handshake, as a triplet {idly, pls, edly}.
- Per command it emits one RF gate pulse on PULSE_OUT:
  - idly cycles low,
  - then pls cycles high,
  - then edly cycles low,
  - then it reports completion on BT_DONE.
- It drives the TX pulse gate of the NMR front end. It is the block whose BT_DONE the sequencer polls before issuing the next command.

Parameters:
- IDLY_WIDTH, 32, width of the initial-delay count
- PLS_WIDTH, 32, width of the pulse-length count
- EDLY_WIDTH, 32, width of the post-pulse delay count
- GATE_PRE, 8, lead cycles for GATE_OUT (used only with NMR_PLS_GATE_EN)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- BT_START  in  1  command strobe from sequencer; rising edge starts a command
- BT_DONE  out  1  high = idle/ready; low while a command executes
- idly_reg  in  IDLY_WIDTH  initial delay in CLK cycles
- pls_reg  in  PLS_WIDTH  pulse length in CLK cycles
- edly_reg  in  EDLY_WIDTH  post-pulse delay in CLK cycles
- PULSE_OUT  out  1  registered pulse output
- BUSY  out  1  high when state != IDLE
- START_IGN  out  1  sticky; set when a BT_START rising edge arrives while busy; cleared only by RST
- GATE_OUT  out  1  amplifier gate; present only with NMR_PLS_GATE_EN

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; BT_DONE=1; PULSE_OUT=0; BUSY=0; START_IGN=0; GATE_OUT=0.
  - Counters and latched parameters cleared; BT_START edge-detect register cleared to 0.
  - Reset mid-command aborts immediately. No pulse tail is emitted.
- Start detection:
  - start_edge = BT_START & ~bt_start_q, where bt_start_q is BT_START registered.
  - A level held high never retriggers.
  - Inputs idly_reg/pls_reg/edly_reg are valid only in the cycle start_edge is seen. They are latched internally at that edge; later input changes have no effect on the running command.
- States: IDLE, IDLY, PLS, EDLY, END (one-hot or encoded; implementer's choice).
  - IDLE: on start_edge (edge k) → latch I, P, E; BT_DONE<=0; go to the first phase with nonzero count (IDLY, then PLS, then EDLY); if I=P=E=0 go to END.
  - IDLY/PLS/EDLY: down-counter loaded with N-1 on entry. Each phase occupies exactly N cycles, then goes to the next nonzero phase, else END. A phase with count 0 is skipped entirely.
  - END: exactly 1 cycle; on exit BT_DONE<=1, state<=IDLE.
- Timing (edge k = edge sampling start_edge):
  - PULSE_OUT=1 from edge k+I to edge k+I+P; exactly P cycles high. P=0 gives no pulse.
  - BT_DONE low from edge k to edge k+I+P+E+1. Minimum low time is 1 cycle.
  - BUSY = (state != IDLE); low again at edge k+I+P+E+1.
- start_edge while not IDLE: ignored and START_IGN<=1. No truncation or restart of the running command.
- Counter width: each phase counter is its parameter width. Max value 2^W-1 is legal; no wrap into the next phase.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro NMR_PLS_GATE_EN.
- Defined: GATE_OUT is asserted for the last min(GATE_PRE, I) cycles of IDLY and through all of PLS. It deasserts on the same edge PULSE_OUT falls. If P=0, GATE_OUT is never asserted for that command.
- Undefined: the GATE_OUT port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: RST pulse, no BT_START → BT_DONE=1, PULSE_OUT=0, BUSY=0, START_IGN=0.
- Basic command I=5, P=3, E=4 → PULSE_OUT high exactly cycles k+5..k+7; BT_DONE low exactly 13 cycles (k..k+12).
- Zero phases: I=0, P=2, E=0 → PULSE_OUT high at k, k+1; BT_DONE low 3 cycles. I=P=E=0 → no pulse; BT_DONE low 1 cycle.
- Start while busy, and inputs changed after latch: I=10, P=10, E=10, second BT_START edge at k+6 with new values 1/1/1 → original timing unchanged; START_IGN=1. BT_START held high 20 cycles → exactly one command.
- Reset mid-pulse: RST asserted at k+I+1 of I=4, P=8 → PULSE_OUT and BUSY drop asynchronously; BT_DONE=1; next command runs normally.
- NMR_PLS_GATE_EN, GATE_PRE=8:
  - I=20, P=5 → GATE_OUT high k+12..k+24, falls together with PULSE_OUT.
  - I=3, P=5 → GATE_OUT high from k.
